// File: rtl/lgn_seq_pkg.sv
// Shared types and sizing helpers for the LGN image sequencer.
package lgn_seq_pkg;

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StCapture} seq_state_e;

    typedef logic [3:0] class_idx_t;

    localparam int unsigned DEF_BYTES_PER_IMG = 32;
    localparam int unsigned DEF_PIPE_LATENCY  = 3;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int unsigned min_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned BYTE_CNT_W  = min_width(DEF_BYTES_PER_IMG);
    localparam int unsigned DRAIN_CNT_W = min_width(DEF_PIPE_LATENCY + 1);

endpackage

// File: rtl/lgn_seq_tick_timer.sv
// Free-running period counter; tick_o pulses for one cycle every PERIOD cycles from reset.
module lgn_seq_tick_timer
    import lgn_seq_pkg::*;
#(
    parameter int unsigned PERIOD = 12000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int unsigned TW = min_width(PERIOD);
    localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_o <= 1'b0;
        end else begin
            tick_o <= (cnt_q == LAST);
            cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/lgn_image_sequencer.sv
// Streams one stored image from ROM into the LGN core and captures its class index.
// Define AUTO_ADVANCE_EN to add a periodic image-select advance timer.
module lgn_image_sequencer
    import lgn_seq_pkg::*;
#(
    parameter int unsigned NUM_IMAGES    = 4,
    parameter int unsigned BYTES_PER_IMG = DEF_BYTES_PER_IMG,
    parameter int unsigned PIPE_LATENCY  = DEF_PIPE_LATENCY,
    parameter int unsigned TIMER_TICKS   = 12000000,
    localparam int unsigned AW = min_width(NUM_IMAGES * BYTES_PER_IMG),
    localparam int unsigned IW = min_width(NUM_IMAGES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          run_i,
    input  logic          next_i,
    output logic [AW-1:0] mem_addr_o,
    input  logic [7:0]    mem_data_i,
    output logic [7:0]    core_data_o,
    output logic          frame_start_o,
    input  logic [3:0]    core_index_i,
    output logic [IW-1:0] img_sel_o,
    output logic [3:0]    result_o,
    output logic          result_valid_o,
    output logic          busy_o
);

    localparam int unsigned CW = min_width(BYTES_PER_IMG);
    localparam int unsigned DW = min_width(PIPE_LATENCY + 1);
    localparam logic [CW-1:0] LAST_BYTE  = CW'(BYTES_PER_IMG - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(PIPE_LATENCY);
    localparam logic [IW-1:0] LAST_IMG   = IW'(NUM_IMAGES - 1);

    seq_state_e    state_q;
    logic [CW-1:0] byte_q;
    logic [DW-1:0] drain_q;
    logic [IW-1:0] img_q;
    logic          pend_q;
    logic [AW-1:0] addr_q;
    logic          fetch_q;
    logic          first_q;
    logic [7:0]    data_q;
    logic          sof_q;
    class_idx_t    result_q;
    logic          valid_q;

    logic          adv_req;
    logic [IW-1:0] img_next;
    logic [IW-1:0] img_cap;

`ifdef AUTO_ADVANCE_EN
    logic tick;

    lgn_seq_tick_timer #(
        .PERIOD(TIMER_TICKS)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .tick_o(tick)
    );

    assign adv_req = next_i | tick;
`else
    assign adv_req = next_i;
`endif

    function automatic logic [AW-1:0] img_base(input logic [IW-1:0] img);
        return AW'(img) * AW'(BYTES_PER_IMG);
    endfunction

    assign img_next = (img_q == LAST_IMG) ? '0 : img_q + IW'(1);
    // Image used by a back-to-back frame launched from the capture cycle.
    assign img_cap  = (pend_q | adv_req) ? img_next : img_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            byte_q   <= '0;
            drain_q  <= '0;
            img_q    <= '0;
            pend_q   <= 1'b0;
            addr_q   <= '0;
            fetch_q  <= 1'b0;
            first_q  <= 1'b0;
            data_q   <= 8'h00;
            sof_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            // ROM data lags the address by one cycle; track which cycles carry a real byte.
            fetch_q <= (state_q == StFetch);
            first_q <= (state_q == StFetch) && (byte_q == '0);
            data_q  <= fetch_q ? mem_data_i : 8'h00;
            sof_q   <= first_q;
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i | run_i) begin
                        state_q <= StFetch;
                        byte_q  <= '0;
                        addr_q  <= img_base(img_q);
                        pend_q  <= adv_req;
                    end else if (adv_req) begin
                        img_q <= img_next;
                    end
                end
                StFetch: begin
                    pend_q <= pend_q | adv_req;
                    if (byte_q == LAST_BYTE) begin
                        state_q <= StDrain;
                        drain_q <= '0;
                        addr_q  <= '0;
                    end else begin
                        byte_q <= byte_q + CW'(1);
                        addr_q <= addr_q + AW'(1);
                    end
                end
                StDrain: begin
                    pend_q <= pend_q | adv_req;
                    if (drain_q == LAST_DRAIN) begin
                        state_q <= StCapture;
                        valid_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                StCapture: begin
                    result_q <= core_index_i;
                    pend_q   <= 1'b0;
                    img_q    <= img_cap;
                    if (run_i) begin
                        state_q <= StFetch;
                        byte_q  <= '0;
                        addr_q  <= img_base(img_cap);
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_addr_o     = addr_q;
    assign core_data_o    = data_q;
    assign frame_start_o  = sof_q;
    assign img_sel_o      = img_q;
    assign busy_o         = (state_q != StIdle);
    assign result_valid_o = valid_q;
    // The index is only valid in the capture cycle, so it is passed straight through there.
    assign result_o       = valid_q ? core_index_i : result_q;

endmodule
